// File: rtl/beat_judge.sv
// rtl/beat_judge.sv - judges each beat window as PERFECT, GOOD or MISS and keeps score, combo and lives
module beat_judge #(
    parameter int LIVES      = 3,
    parameter int SCORE_W    = 8,
    parameter int PERFECT_TH = 2
) (
    input  logic               clk,
    input  logic               INIT,
    input  logic               gameState,
    input  logic               window,
    input  logic [3:0]         remain,
    input  logic [3:0]         target,
    input  logic [3:0]         keys,
    output logic               hit,
    output logic               perfect,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         combo,
    output logic [1:0]         lives,
    output logic               game_over
);

    typedef enum logic [1:0] {IDLE, ARMED, DONE, OVER} state_t;

    state_t             state;
    logic               window_d;
    logic [3:0]         keys_d;
    logic [3:0]         press;
    logic               win_rise;
    logic               win_fall;
    logic               early;
    logic               judge_hit;
    logic               judge_miss;
    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] score_next;

    // Edge detection, grading and the hit/miss decision for the current cycle
    always_comb begin
        press      = keys & ~keys_d;
        win_rise   = window & ~window_d;
        win_fall   = ~window & window_d;
        early      = (remain >= 4'(PERFECT_TH));
        // early hits add 2, late hits add 1; the extra top bit catches overflow
        sum        = {1'b0, score} + {{(SCORE_W-1){1'b0}}, early, ~early};
        score_next = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
        judge_hit  = 1'b0;
        judge_miss = 1'b0;
        if (gameState && (state == ARMED)) begin
            if (press != 4'b0000) begin
                judge_hit  = (press == target);
                judge_miss = (press != target);
            end else if (win_fall) begin
                judge_miss = 1'b1;
            end
        end
    end

    // Judging FSM with registered pulses, score, combo and lives
    always_ff @(posedge clk) begin
        if (INIT) begin
            state     <= IDLE;
            hit       <= 1'b0;
            perfect   <= 1'b0;
            miss      <= 1'b0;
            score     <= '0;
            combo     <= 4'd0;
            lives     <= 2'(LIVES);
            game_over <= 1'b0;
            window_d  <= 1'b0;
            keys_d    <= keys;
        end else begin
            window_d <= window;
            keys_d   <= keys;
            hit      <= 1'b0;
            perfect  <= 1'b0;
            miss     <= 1'b0;
            if (gameState) begin
                case (state)
                    IDLE:    if (win_rise) state <= ARMED;
                    ARMED:   if (judge_hit || judge_miss) state <= win_fall ? IDLE : DONE;
                    DONE:    if (win_fall) state <= IDLE;
                    default: state <= OVER;
                endcase
            end
            if (judge_hit) begin
                hit     <= 1'b1;
                perfect <= early;
                score   <= score_next;
                if (combo != 4'hf) combo <= combo + 4'd1;
            end
            if (judge_miss) begin
                miss  <= 1'b1;
                combo <= 4'd0;
                if (lives != 2'd0) lives <= lives - 2'd1;
                // last life gone: overrides the IDLE/DONE choice above
                if (lives <= 2'd1) begin
                    game_over <= 1'b1;
                    state     <= OVER;
                end
            end
        end
    end

endmodule
